// File: rtl/mips_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam int MD_MAX_WIDTH = 64;
  // LO value written on divide by zero; sliced down to the unit's data width.
  localparam logic [MD_MAX_WIDTH-1:0] MD_DIV0_LO = {MD_MAX_WIDTH{1'b1}};

  function automatic logic md_op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] acc_hi,
  input  logic [DATA_WIDTH-1:0] acc_lo,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] acc_hi_next,
  output logic [DATA_WIDTH-1:0] acc_lo_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0] add_s;
  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  // acc_hi holds the product upper half or the partial remainder; acc_lo the
  // multiplier bits still to consume or the dividend bits / quotient.
  always_comb begin
    add_s       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(W+1){1'b0}});
    shifted_s   = {acc_hi, acc_lo[W-1]};
    diff_s      = shifted_s - {1'b0, operand};
    acc_hi_next = acc_hi;
    acc_lo_next = acc_lo;
    if (is_div) begin
      // Borrow out of the W+1 bit subtract means the divisor did not fit.
      if (diff_s[W]) begin
        acc_hi_next = shifted_s[W-1:0];
        acc_lo_next = {acc_lo[W-2:0], 1'b0};
      end else begin
        acc_hi_next = diff_s[W-1:0];
        acc_lo_next = {acc_lo[W-2:0], 1'b1};
      end
    end else begin
      acc_hi_next = add_s[W:1];
      acc_lo_next = {add_s[0], acc_lo[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 1 start + W iterations + 1 fix-up cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_MdStartE,
  input  logic [1:0]            i_MdOpE,
  input  logic [DATA_WIDTH-1:0] i_SrcAE,
  input  logic [DATA_WIDTH-1:0] i_SrcBE,
  input  logic                  i_MthiE,
  input  logic                  i_MtloE,
  input  logic                  i_HiLoAccessD,
  output logic                  o_BusyE,
  output logic                  o_MdStallD,
  output logic                  o_DoneE,
  output logic [DATA_WIDTH-1:0] o_Hi,
  output logic [DATA_WIDTH-1:0] o_Lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);

  md_state_e             state_r, state_nx;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [W-1:0]          acc_hi_r, acc_lo_r, opnd_r;
  logic [W-1:0]          acc_hi_step_s, acc_lo_step_s;
  logic [W-1:0]          hi_r, lo_r, hi_nx, lo_nx;
  logic                  is_div_r, sign_q_r, sign_rem_r, div0_r;
  logic                  busy_r, busy_nx, done_r, done_nx;
  logic                  op_signed_s, op_div_s;
  logic [W-1:0]          mag_a_s, mag_b_s;
  logic [2*W-1:0]        prod_s, prod_fix_s;
  logic [W-1:0]          quot_fix_s, rem_fix_s;

  function automatic logic [W-1:0] abs_if(input logic [W-1:0] v, input logic en);
    return (en && v[W-1]) ? -v : v;
  endfunction

  md_iter_core #(.DATA_WIDTH(W)) u_core (
    .is_div      (is_div_r),
    .acc_hi      (acc_hi_r),
    .acc_lo      (acc_lo_r),
    .operand     (opnd_r),
    .acc_hi_next (acc_hi_step_s),
    .acc_lo_next (acc_lo_step_s)
  );

  // Operand conditioning and final sign correction.
  always_comb begin
    op_signed_s = md_op_signed(i_MdOpE);
    op_div_s    = md_op_is_div(i_MdOpE);
    mag_a_s     = abs_if(i_SrcAE, op_signed_s);
    mag_b_s     = abs_if(i_SrcBE, op_signed_s);
    prod_s      = {acc_hi_r, acc_lo_r};
    prod_fix_s  = sign_q_r ? -prod_s : prod_s;
    quot_fix_s  = sign_q_r ? -acc_lo_r : acc_lo_r;
    rem_fix_s   = sign_rem_r ? -acc_hi_r : acc_hi_r;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nx = state_r;
    done_nx  = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (i_MdStartE) state_nx = MD_RUN;
        else            state_nx = MD_IDLE;
      end
      MD_RUN: begin
        if (cnt_r == LAST_CNT) state_nx = MD_FIX;
        else                   state_nx = MD_RUN;
      end
      MD_FIX: begin
        state_nx = MD_IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = MD_IDLE;
    endcase
    busy_nx = (state_nx != MD_IDLE);
  end

  // HI/LO update: op result in FIX, mthi/mtlo only in IDLE when no op starts.
  always_comb begin
    hi_nx = hi_r;
    lo_nx = lo_r;
    if (state_r == MD_FIX) begin
      if (is_div_r) begin
        hi_nx = rem_fix_s;
        lo_nx = div0_r ? MD_DIV0_LO[W-1:0] : quot_fix_s;
      end else begin
        hi_nx = prod_fix_s[2*W-1:W];
        lo_nx = prod_fix_s[W-1:0];
      end
    end else if ((state_r == MD_IDLE) && !i_MdStartE) begin
      if (i_MthiE) hi_nx = i_SrcAE;
      else         hi_nx = hi_r;
      if (i_MtloE) lo_nx = i_SrcAE;
      else         lo_nx = lo_r;
    end else begin
      hi_nx = hi_r;
      lo_nx = lo_r;
    end
  end

  // State, status and architectural register update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= MD_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      state_r <= state_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      hi_r    <= hi_nx;
      lo_r    <= lo_nx;
    end
  end

  // Iteration datapath; multiply keeps multiplier in acc_lo, divide keeps dividend there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r      <= '0;
      acc_hi_r   <= '0;
      acc_lo_r   <= '0;
      opnd_r     <= '0;
      is_div_r   <= 1'b0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      div0_r     <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (i_MdStartE) begin
            cnt_r      <= '0;
            acc_hi_r   <= '0;
            acc_lo_r   <= op_div_s ? mag_a_s : mag_b_s;
            opnd_r     <= op_div_s ? mag_b_s : mag_a_s;
            is_div_r   <= op_div_s;
            sign_q_r   <= op_signed_s && (i_SrcAE[W-1] ^ i_SrcBE[W-1]);
            sign_rem_r <= op_signed_s && i_SrcAE[W-1];
            div0_r     <= op_div_s && (i_SrcBE == '0);
          end
        end
        MD_RUN: begin
          acc_hi_r <= acc_hi_step_s;
          acc_lo_r <= acc_lo_step_s;
          cnt_r    <= cnt_r + CNT_WIDTH'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign o_BusyE    = busy_r;
  assign o_DoneE    = done_r;
  assign o_Hi       = hi_r;
  assign o_Lo       = lo_r;
  assign o_MdStallD = busy_r & i_HiLoAccessD;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage; executes MULT, MULTU, DIV and DIVU and owns the architectural HI/LO registers.
- Sits beside the ALU and feeds the hazard unit.
- o_BusyE and o_MdStallD drive stall requests that the hazard unit ORs into StallF/StallD/FlushE.
- o_Hi/o_Lo feed the mfhi/mflo result path.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_MdStartE  in  1  valid mult/div op in EX this cycle.
- i_MdOpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_SrcAE  in  DATA_WIDTH  rs operand (multiplicand/dividend), post-forwarding.
- i_SrcBE  in  DATA_WIDTH  rt operand (multiplier/divisor), post-forwarding.
- i_MthiE  in  1  MTHI write request.
- i_MtloE  in  1  MTLO write request.
- i_HiLoAccessD  in  1  instruction in ID is mfhi/mflo/mthi/mtlo/mult/div.
- o_BusyE  out  1  operation in progress.
- o_MdStallD  out  1  stall request to hazard unit.
- o_DoneE  out  1  one-cycle pulse when HI/LO are updated by an op.
- o_Hi  out  DATA_WIDTH  HI register.
- o_Lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, counter=0.
  - o_Hi=0, o_Lo=0, o_BusyE=0, o_DoneE=0.
  - All internal datapath registers cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - On i_MdStartE=1 at edge E0: latch operand magnitudes (abs value for signed ops, raw for unsigned).
  - Also latch result sign (MULT: signA^signB; DIV: quotient signA^signB, remainder signA) and the op.
  - counter=0, go to RUN.
- RUN:
  - One radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - counter++; after DATA_WIDTH iterations (edges E1..E32 at default) go to FIX.
- FIX, at edge E33:
  - Apply sign correction by two's-complement negate when the sign bit is set.
  - Write HI/LO: multiply HI=product[2W-1:W], LO=product[W-1:0]; divide LO=quotient, HI=remainder.
  - o_DoneE=1 for exactly that cycle; return to IDLE.
- Latency: start edge to HI/LO visible is DATA_WIDTH+1 edges (33).
- o_BusyE:
  - Registered; high whenever state != IDLE (33 cycles at default).
  - A new start is accepted in the cycle o_DoneE is high (state is IDLE).
- o_MdStallD = o_BusyE & i_HiLoAccessD (combinational).
  - Guarantees no HI/LO read, write or new op issues while busy.
- i_MdStartE while busy: ignored (the stall makes this illegal; the bench asserts it never occurs).
- MTHI/MTLO:
  - Accepted only in IDLE; write i_SrcAE to HI/LO at the edge.
  - Same-cycle i_MdStartE has priority and the mt write is dropped.
- Divide by zero: FIX writes HI=dividend (original signed value), LO=all ones; no trap.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- Reset mid-operation: immediate return to IDLE and HI/LO=0; the partial result is discarded.
- Width rules: the product accumulator is 2*DATA_WIDTH; the divide partial remainder is DATA_WIDTH+1 for the subtract borrow.

Decomposition:
- Shared package (mips_pkg):
  - MD_OP_MULT/MULTU/DIV/DIVU encodings.
  - FSM state encoding MD_IDLE/MD_RUN/MD_FIX.
  - MD_DIV0_LO constant (all ones).
- One sub-module, md_iter_core: per-cycle shift-add/shift-subtract datapath step.
- The top level keeps the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULT 0xFFFFFFFF x 0x00000002: HI=0xFFFFFFFF, LO=0xFFFFFFFE 33 edges after start; o_DoneE high one cycle.
- MULTU 0xFFFFFFFF x 0x00000002: HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 0x00000002: LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2: LO=3, HI=1.
- DIVU 0x00000007 / 0: HI=0x00000007, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Start MULT, then hold i_HiLoAccessD=1 from the next cycle:
  - o_BusyE=1 and o_MdStallD=1 for 33 cycles, both 0 in the o_DoneE cycle.
  - A back-to-back start in that cycle is accepted.
- Reset mid-op: assert i_rst_n=0 asynchronously at iteration 10 of a DIV.
  - o_BusyE, o_Hi, o_Lo go to 0 without a clock edge; after release, MTHI 0x1234 in IDLE gives o_Hi=0x00001234 next cycle.
